// File: rtl/asrv32_bus_initiator.sv
`default_nettype none
// ============================================================================
// asrv32_bus_initiator : stb/ack data-memory initiator for byte/half/word
//                        loads and stores, with alignment checks and timeout.
// Revision 1.0
// ============================================================================
module asrv32_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_stb,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wr_mask,
    output logic        o_wr_en,
    input  logic        i_ack,
    input  logic [31:0] i_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    err_code, err_code_nx;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;

    logic          misaligned;
    logic          issue;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;
    logic [3:0]    lane_mask;
    logic [31:0]   lane_wdata;

    assign misaligned = ((i_size == 2'b01) && i_addr[0]) ||
                        ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));

    always_comb begin
        state_nx    = state;
        err_code_nx = err_code;
        case (state)
            S_IDLE: begin
                if (i_req) begin
                    if (i_size == 2'b11) begin
                        state_nx    = S_DONE;
                        err_code_nx = ERR_SIZE;
                    end else if (misaligned) begin
                        state_nx    = S_DONE;
                        err_code_nx = ERR_MISALIGN;
                    end else begin
                        state_nx    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                // an ack on the last permitted cycle still counts as success
                if (i_ack) begin
                    state_nx = S_DONE;
                end else if (cnt == C_TO_LAST) begin
                    state_nx    = S_DONE;
                    err_code_nx = ERR_TIMEOUT;
                end
            end
            S_DONE: begin
                state_nx    = S_IDLE;
                err_code_nx = ERR_NONE;
            end
            default: begin
                state_nx    = S_IDLE;
                err_code_nx = ERR_NONE;
            end
        endcase
    end

    assign shifted = i_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011 << addr_q[1:0];
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            err_code <= ERR_NONE;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            wdata_q  <= 32'd0;
            cnt      <= '0;
            rdata_q  <= 32'd0;
        end else begin
            state    <= state_nx;
            err_code <= err_code_nx;
            if (state == S_IDLE && i_req) begin
                we_q    <= i_we;
                addr_q  <= i_addr;
                size_q  <= i_size;
                uns_q   <= i_unsigned;
                wdata_q <= i_wdata;
            end
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (state == S_WAIT && i_ack && !we_q) begin
                rdata_q <= load_ext;
            end
        end
    end

    // Bus outputs decode straight from state so a reset kills them at once.
    assign issue      = (state == S_ISSUE);
    assign o_stb      = issue;
    assign o_wr_en    = issue & we_q;
    assign o_addr     = issue ? {addr_q[31:2], 2'b00} : 32'd0;
    assign o_wr_mask  = (issue && we_q) ? lane_mask : 4'b0000;
    assign o_wdata    = issue ? lane_wdata : 32'd0;

    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
    assign o_err_code = err_code;
    assign o_err      = |err_code;
    assign o_rdata    = rdata_q;

endmodule
`default_nettype wire
